pong_game_sequencer: RTL
========================

Name: pong_game_sequencer

Overview:
Top-level game-flow controller for the VGA Pong datapath. It sequences IDLE/SERVE/PLAY/GAME-OVER and gates paddle motion through play_en, which drives the paddle controllers' start input. It steps the ball on a cell grid and detects paddle hits against the two paddle heights. It keeps score and drives a ball pixel-enable from the VGA scan counters.

Parameters:
SCREEN_WIDTH, 40, grid columns; left paddle at column 0, right paddle at column SCREEN_WIDTH-1
SCREEN_HEIGHT, 30, grid rows
PADDLE_HEIGHT, 6, paddle spans rows height..height+PADDLE_HEIGHT inclusive (same as paddle controllers)
BALL_DELAY, 2500000, clk cycles per ball step
SERVE_DELAY, 50000000, clk cycles spent in SERVE before PLAY
WIN_SCORE, 7, points needed to win (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  start/restart button, level; rising edge detected internally
left_height  in  6  top row of left paddle
right_height  in  6  top row of right paddle
hori_cnt  in  10  VGA column (grid units)
vert_cnt  in  10  VGA row (grid units)
play_en  out  1  paddle motion enable
ball_on  out  1  current scan cell is the ball
ball_x  out  6  ball column
ball_y  out  6  ball row
score_l  out  4  left score
score_r  out  4  right score
winner  out  2  0 none, 1 left, 2 right
state  out  2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER

Behaviour:
- Reset (clk edge with reset=1): state=IDLE, ball_x=SCREEN_WIDTH/2, ball_y=SCREEN_HEIGHT/2, dir_x=right, dir_y=down, scores=0, winner=0, all counters=0, start_q=0. Reset overrides every other event and applies mid-game.
- Edge detect: start_q is a registered copy of start. start_pulse = start & ~start_q. A held button produces exactly one pulse.
- play_en = (state==SERVE || state==PLAY), combinational.
- ball_on = play_en && hori_cnt==ball_x && vert_cnt==ball_y, combinational, zero-extended compare.
- IDLE: on start_pulse -> SERVE on the next cycle.
- SERVE: ball held at centre. Delay counter counts 0..SERVE_DELAY-1; at SERVE_DELAY-1 -> PLAY and the counter clears. start is ignored.
- PLAY: step counter counts 0..BALL_DELAY-1. A tick occurs at BALL_DELAY-1, then the counter wraps to 0. The counter is held at 0 outside PLAY. The first tick comes BALL_DELAY cycles after PLAY entry. All updates below happen only on a tick and use pre-tick values.
  - Y motion: moving down and ball_y==SCREEN_HEIGHT-1 -> dir_y=up, ball_y-1. Moving up and ball_y==0 -> dir_y=down, ball_y+1. Otherwise ball_y±1.
  - X motion: moving left with ball_x==1 -> paddle check vs left_height. Moving right with ball_x==SCREEN_WIDTH-2 -> paddle check vs right_height. Otherwise ball_x±1.
  - Hit: h <= ball_y <= h+PADDLE_HEIGHT, computed at 7 bits with no wrap. On a hit dir_x flips and ball_x steps one cell away from the paddle (2 or SCREEN_WIDTH-3). Y still updates.
  - Miss: the opponent's score +1. Ball goes to centre with dir_x pointing toward the player who missed; dir_y is kept. If the new score == WIN_SCORE -> OVER with winner=1 or 2; else -> SERVE.
- OVER: play_en=0, ball_on=0, scores and winner held. On start_pulse: scores=0, winner=0, ball to centre, dir_x=right -> SERVE.
- start during SERVE/PLAY has no effect. Only one score event per tick.

Test Plan:
- Reset hold 3 cycles, then release -> state=0, ball=(20,15), scores 0, play_en=0, ball_on=0. Hold start high 10 cycles -> exactly one IDLE->SERVE transition.
- BALL_DELAY=4, SERVE_DELAY=8, start pulse at cycle N -> state=1 at N+1, state=2 at N+9, first tick at N+13 -> ball=(21,16).
- Same params, no paddle movement: tick 14 ball_y=29; tick 15 ball_y=28, dir up; tick 18 ball=(38,25).
- right_height=20 at tick 19 (ball_y 25 within 20..26) -> hit, ball_x=37, dir left, score unchanged. With right_height=0 instead -> score_l=1, ball=(20,15), state=SERVE, next serve moves right.
- Force left misses until score_r=7 (WIN_SCORE=7) -> state=3, winner=2, play_en=0. start pulse -> scores 0, winner 0, state=1.
- Assert reset mid-PLAY while step counter is nonzero -> next cycle all outputs at reset values, step counter 0.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: IDLE/SERVE/PLAY/OVER sequencing, ball stepping on the
// cell grid, paddle hit detection, scoring and the ball pixel-enable for the VGA scan.
module pong_game_sequencer #(
  parameter int SCREEN_WIDTH  = 40,
  parameter int SCREEN_HEIGHT = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int BALL_DELAY    = 2500000,
  parameter int SERVE_DELAY   = 50000000,
  parameter int WIN_SCORE     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] left_height,
  input  logic [5:0] right_height,
  input  logic [9:0] hori_cnt,
  input  logic [9:0] vert_cnt,
  output logic       play_en,
  output logic       ball_on,
  output logic [5:0] ball_x,
  output logic [5:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int SERVE_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int STEP_W  = (BALL_DELAY > 1) ? $clog2(BALL_DELAY) : 1;

  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_DELAY - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(BALL_DELAY - 1);
  localparam logic [5:0] X_MID        = 6'(SCREEN_WIDTH / 2);
  localparam logic [5:0] Y_MID        = 6'(SCREEN_HEIGHT / 2);
  localparam logic [5:0] X_LEFT_EDGE  = 6'd1;
  localparam logic [5:0] X_LEFT_OUT   = 6'd2;
  localparam logic [5:0] X_RIGHT_EDGE = 6'(SCREEN_WIDTH - 2);
  localparam logic [5:0] X_RIGHT_OUT  = 6'(SCREEN_WIDTH - 3);
  localparam logic [5:0] Y_LAST       = 6'(SCREEN_HEIGHT - 1);
  localparam logic [3:0] WIN          = 4'(WIN_SCORE);

  state_t               state_q, state_d;
  logic                 start_q;
  logic [SERVE_W-1:0]   serve_cnt;
  logic [STEP_W-1:0]    step_cnt;
  logic                 dir_x;   // 1 = moving right
  logic                 dir_y;   // 1 = moving down

  // Paddle range is compared at 7 bits so a paddle near row 63 never wraps onto row 0.
  function automatic logic paddle_hit(input logic [5:0] h, input logic [5:0] y);
    logic [6:0] top;
    logic [6:0] bot;
    top = {1'b0, h};
    bot = top + 7'(PADDLE_HEIGHT);
    return ({1'b0, y} >= top) && ({1'b0, y} <= bot);
  endfunction

  logic       start_pulse;
  logic       tick;
  logic       at_left, at_right;
  logic       hit_l, hit_r, miss_l, miss_r;
  logic [3:0] score_l_inc, score_r_inc;
  logic       point_over, game_won;

  assign start_pulse = start & ~start_q;
  assign tick        = (state_q == PLAY) && (step_cnt == STEP_LAST);
  assign at_left     = !dir_x && (ball_x == X_LEFT_EDGE);
  assign at_right    = dir_x && (ball_x == X_RIGHT_EDGE);
  assign hit_l       = at_left && paddle_hit(left_height, ball_y);
  assign hit_r       = at_right && paddle_hit(right_height, ball_y);
  assign miss_l      = at_left && !hit_l;
  assign miss_r      = at_right && !hit_r;
  assign score_l_inc = score_l + 4'd1;
  assign score_r_inc = score_r + 4'd1;
  assign point_over  = tick && (miss_l || miss_r);
  assign game_won    = (miss_l && (score_r_inc == WIN)) || (miss_r && (score_l_inc == WIN));
  assign state       = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_pulse) state_d = SERVE;
      SERVE:   if (serve_cnt == SERVE_LAST) state_d = PLAY;
      PLAY:    if (point_over) state_d = game_won ? OVER : SERVE;
      OVER:    if (start_pulse) state_d = SERVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    play_en = (state_q == SERVE) || (state_q == PLAY);
    ball_on = play_en && (hori_cnt == {4'b0, ball_x}) && (vert_cnt == {4'b0, ball_y});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= 1'b0;
      serve_cnt <= '0;
      step_cnt  <= '0;
      ball_x    <= X_MID;
      ball_y    <= Y_MID;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      winner    <= 2'd0;
    end else begin
      start_q   <= start;
      serve_cnt <= (state_q == SERVE && serve_cnt != SERVE_LAST) ? serve_cnt + 1'b1 : '0;
      step_cnt  <= (state_q == PLAY && !tick) ? step_cnt + 1'b1 : '0;

      if (point_over) begin
        // Re-serve from centre toward the player who just missed; vertical direction is kept.
        ball_x <= X_MID;
        ball_y <= Y_MID;
        dir_x  <= miss_r;
        if (miss_l) begin
          score_r <= score_r_inc;
          if (score_r_inc == WIN) winner <= 2'd2;
        end else begin
          score_l <= score_l_inc;
          if (score_l_inc == WIN) winner <= 2'd1;
        end
      end else if (tick) begin
        if (dir_y && ball_y == Y_LAST) begin
          dir_y  <= 1'b0;
          ball_y <= ball_y - 6'd1;
        end else if (!dir_y && ball_y == 6'd0) begin
          dir_y  <= 1'b1;
          ball_y <= ball_y + 6'd1;
        end else begin
          ball_y <= dir_y ? ball_y + 6'd1 : ball_y - 6'd1;
        end

        if (hit_l) begin
          dir_x  <= 1'b1;
          ball_x <= X_LEFT_OUT;
        end else if (hit_r) begin
          dir_x  <= 1'b0;
          ball_x <= X_RIGHT_OUT;
        end else begin
          ball_x <= dir_x ? ball_x + 6'd1 : ball_x - 6'd1;
        end
      end

      if (state_q == OVER && start_pulse) begin
        score_l <= 4'd0;
        score_r <= 4'd0;
        winner  <= 2'd0;
        ball_x  <= X_MID;
        ball_y  <= Y_MID;
        dir_x   <= 1'b1;
      end
    end
  end

endmodule
